// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register bank; oversampled on aclk with
// per-line synchroniser and glitch filter, pointer auto-increment with wrap.
module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDR   = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_W      = 4,
    parameter int         FILTER_LEN = 3
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe_o,
    output logic [8*NUM_REGS-1:0] regs_o,
    output logic                  wr_stb_o,
    output logic [PTR_W-1:0]      wr_idx_o,
    output logic                  rd_stb_o,
    output logic                  busy_o,
    output logic [3:0]            dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
    } state_t;

    // Line index 0 = SCL, 1 = SDA.
    logic [1:0]      r_s1, r_s2, r_flt, r_flt_d;
    logic [1:0][3:0] r_cnt;
    logic [1:0]      w_pad;

    assign w_pad = {sda_i, scl_i};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1    <= '1;
            r_s2    <= '1;
            r_flt   <= '1;
            r_flt_d <= '1;
            r_cnt   <= '0;
        end else begin
            r_s1    <= w_pad;
            r_s2    <= r_s1;
            r_flt_d <= r_flt;
            for (int i = 0; i < 2; i++) begin
                // Any sample equal to the current level restarts the run.
                if (r_s2[i] == r_flt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == 4'(FILTER_LEN - 1)) begin
                    r_flt[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = r_flt[0] & ~r_flt_d[0];
    assign w_scl_fall = ~r_flt[0] & r_flt_d[0];
    assign w_start    = r_flt[0] & r_flt_d[0] & r_flt_d[1] & ~r_flt[1];
    assign w_stop     = r_flt[0] & r_flt_d[0] & ~r_flt_d[1] & r_flt[1];

    state_t           r_state;
    logic [7:0]       r_shift, r_wdata;
    logic [3:0]       r_bit_cnt;
    logic [PTR_W-1:0] r_ptr, r_wr_idx;
    logic             r_rw, r_phase, r_sda_oe, r_wr_stb, r_rd_stb, r_busy;
    logic [7:0]       r_regs [NUM_REGS];

    logic [7:0]       w_rx_byte;
    logic [PTR_W-1:0] w_ptr_inc, w_ptr_new;
    assign w_rx_byte = {r_shift[6:0], r_flt[1]};
    assign w_ptr_inc = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
    assign w_ptr_new = ({1'b0, w_rx_byte} < 9'(NUM_REGS)) ? PTR_W'(w_rx_byte) : '0;

    // r_phase: in the ACK states, 1 once the ACK bit is being driven (or,
    // in S_RACK, once the controller's ACK has been seen).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_wdata   <= '0;
            r_bit_cnt <= '0;
            r_ptr     <= '0;
            r_wr_idx  <= '0;
            r_rw      <= 1'b0;
            r_phase   <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_wr_stb <= 1'b0;
            r_rd_stb <= 1'b0;
            if (w_stop) begin
                r_state   <= S_IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= '0;
                r_phase   <= 1'b0;
            end else if (w_start) begin
                r_state   <= S_ADDR;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                r_phase   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_rx_byte;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= '0;
                                r_phase   <= 1'b0;
                                if (r_state == S_ADDR) begin
                                    if (w_rx_byte[7:1] == I2C_ADDR) begin
                                        r_state <= S_ADDR_ACK;
                                        r_rw    <= w_rx_byte[0];
                                        r_busy  <= 1'b1;
                                    end else begin
                                        r_state <= S_IDLE;
                                    end
                                end else if (r_state == S_PTR) begin
                                    r_ptr   <= w_ptr_new;
                                    r_state <= S_PTR_ACK;
                                end else begin
                                    r_wr_stb <= 1'b1;
                                    r_wr_idx <= r_ptr;
                                    r_wdata  <= w_rx_byte;
                                    r_state  <= S_WDATA_ACK;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= 1'b1;
                                r_phase  <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_state  <= S_RDATA;
                                    r_sda_oe <= ~r_shift[7];
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                                    if (r_state == S_WDATA_ACK) r_ptr <= w_ptr_inc;
                                end
                            end
                        end else if (w_scl_rise && r_phase && r_rw && r_state == S_ADDR_ACK) begin
                            r_shift  <= r_regs[r_ptr];
                            r_rd_stb <= 1'b1;
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= '0;
                                r_phase   <= 1'b0;
                                r_state   <= S_RACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    S_RACK: begin
                        if (w_scl_rise) begin
                            if (!r_flt[1]) begin
                                r_phase  <= 1'b1;
                                r_ptr    <= w_ptr_inc;
                                r_shift  <= r_regs[w_ptr_inc];
                                r_rd_stb <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_phase  <= 1'b0;
                            r_state  <= S_RDATA;
                            r_sda_oe <= ~r_shift[7];
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Bank write lands one cycle after the strobe.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else if (r_wr_stb) begin
            r_regs[r_wr_idx] <= r_wdata;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[8*g +: 8] = r_regs[g];
    end

    assign sda_oe_o    = r_sda_oe;
    assign wr_stb_o    = r_wr_stb;
    assign wr_idx_o    = r_wr_idx;
    assign rd_stb_o    = r_rd_stb;
    assign busy_o      = r_busy;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged controller on an
// open-drain bus model, with a write-index scoreboard and a bank model.
`timescale 1ns/100ps
module tb_i2c_target_regs;

    localparam int Q = 20;  // aclk cycles per quarter SCL period: 8 MHz / 80 = 100 kHz

    logic         aclk, aresetn, m_scl, m_sda;
    logic         sda_i, sda_oe_o, wr_stb_o, rd_stb_o, busy_o;
    logic [127:0] regs_o;
    logic [3:0]   wr_idx_o, dbg_state_o;

    logic [3:0]   exp_q[$];
    logic [3:0]   obs_q[$];
    logic [7:0]   exp_regs [16];
    int           n_total, n_bad, rd_cnt;

    assign sda_i = m_sda & ~sda_oe_o;

    i2c_target_regs #(.I2C_ADDR(7'h50), .NUM_REGS(16), .PTR_W(4), .FILTER_LEN(3)) dut (
        .aclk(aclk), .aresetn(aresetn), .scl_i(m_scl), .sda_i(sda_i),
        .sda_oe_o(sda_oe_o), .regs_o(regs_o), .wr_stb_o(wr_stb_o),
        .wr_idx_o(wr_idx_o), .rd_stb_o(rd_stb_o), .busy_o(busy_o),
        .dbg_state_o(dbg_state_o)
    );

    initial aclk = 1'b0;
    always #62.5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (wr_stb_o) obs_q.push_back(wr_idx_o);
            if (rd_stb_o) rd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reg_of(input int k);
        return regs_o[8*k +: 8];
    endfunction

    task automatic exp_write(input logic [3:0] idx, input logic [7:0] data);
        exp_q.push_back(idx);
        exp_regs[idx] = data;
    endtask

    task automatic check_wr(input string tag);
        check({tag, "_wr_cnt"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_wr_idx"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_bank(input string tag);
        for (int k = 0; k < 16; k++) check($sformatf("%s_reg%0d", tag, k), reg_of(k), exp_regs[k]);
    endtask

    task automatic quarter();
        repeat (Q) @(posedge aclk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; quarter();
        m_scl = 1'b1; quarter();
        m_sda = 1'b0; quarter();
        m_scl = 1'b0; quarter();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; quarter();
        m_scl = 1'b1; quarter();
        m_sda = 1'b1; quarter();
        quarter();
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        m_sda = b; quarter();
        m_scl = 1'b1; quarter();
        if (glitch) begin
            m_scl = 1'b0;
            repeat (2) @(posedge aclk);
            m_scl = 1'b1;
        end
        quarter();
        m_scl = 1'b0; quarter();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; quarter();
        m_scl = 1'b1; quarter();
        @(negedge aclk);
        b = sda_i;
        quarter();
        m_scl = 1'b0; quarter();
    endtask

    task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack, 1'b0);
    endtask

    logic       ack;
    logic [7:0] rd;

    initial begin
        n_total = 0; n_bad = 0; rd_cnt = 0;
        for (int k = 0; k < 16; k++) exp_regs[k] = 8'h00;
        m_scl = 1'b1; m_sda = 1'b1; aresetn = 1'b0;
        repeat (5) @(negedge aclk);
        check("rst_sda_oe", sda_oe_o, 0);
        check("rst_regs_any", |regs_o, 0);
        check("rst_wr_stb", wr_stb_o, 0);
        check("rst_wr_idx", wr_idx_o, 0);
        check("rst_rd_stb", rd_stb_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_state", dbg_state_o, 0);
        aresetn = 1'b1;
        repeat (10) @(posedge aclk);

        // Write 0x11, 0x22 from pointer 2
        i2c_start();
        send_byte(8'hA0, -1, ack); check("t1_addr_ack", ack, 1);
        check("t1_busy", busy_o, 1);
        send_byte(8'h02, -1, ack); check("t1_ptr_ack", ack, 1);
        send_byte(8'h11, -1, ack); check("t1_d0_ack", ack, 1); exp_write(4'd2, 8'h11);
        send_byte(8'h22, -1, ack); check("t1_d1_ack", ack, 1); exp_write(4'd3, 8'h22);
        i2c_stop();
        check("t1_busy_after_stop", busy_o, 0);
        check_wr("t1");
        check("t1_reg2", reg_of(2), 8'h11);
        check("t1_reg3", reg_of(3), 8'h22);

        // Readback through repeated START
        rd_cnt = 0;
        i2c_start();
        send_byte(8'hA0, -1, ack); check("t2_addr_ack", ack, 1);
        send_byte(8'h02, -1, ack); check("t2_ptr_ack", ack, 1);
        i2c_start();
        send_byte(8'hA1, -1, ack); check("t2_raddr_ack", ack, 1);
        recv_byte(rd, 1'b1); check("t2_rd0", rd, 8'h11);
        recv_byte(rd, 1'b0); check("t2_rd1", rd, 8'h22);
        check("t2_busy_after_nack", busy_o, 1);
        i2c_stop();
        check("t2_rd_stb_cnt", rd_cnt, 2);
        check("t2_busy_after_stop", busy_o, 0);
        check_wr("t2");

        // Wrong address is NACKed and ignored
        i2c_start();
        send_byte(8'hB0, -1, ack); check("t3_addr_nack", ack, 0);
        check("t3_busy", busy_o, 0);
        send_byte(8'h55, -1, ack); check("t3_data_nack", ack, 0);
        i2c_stop();
        check_wr("t3");

        // Pointer wrap and out-of-range pointer
        i2c_start();
        send_byte(8'hA0, -1, ack); check("t4_addr_ack", ack, 1);
        send_byte(8'h0F, -1, ack); check("t4_ptr_ack", ack, 1);
        send_byte(8'hAA, -1, ack); exp_write(4'd15, 8'hAA);
        send_byte(8'hBB, -1, ack); exp_write(4'd0, 8'hBB);
        i2c_stop();
        check_wr("t4a");
        check("t4_reg15", reg_of(15), 8'hAA);
        check("t4_reg0", reg_of(0), 8'hBB);
        i2c_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h40, -1, ack); check("t4_ptr_oor_ack", ack, 1);
        send_byte(8'hCC, -1, ack); exp_write(4'd0, 8'hCC);
        i2c_stop();
        check_wr("t4b");
        check("t4_reg0_oor", reg_of(0), 8'hCC);

        // STOP after 5 data bits discards the byte
        i2c_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h04, -1, ack);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        i2c_stop();
        check_wr("t5");
        check("t5_state_idle", dbg_state_o, 0);
        check("t5_sda_oe", sda_oe_o, 0);
        check_bank("t5");

        // Reset while driving a 0 bit: ptr is still 4, reg4 = 0x00
        rd_cnt = 0;
        i2c_start();
        send_byte(8'hA1, -1, ack); check("t6_addr_ack", ack, 1);
        @(negedge aclk);
        check("t6_rd_stb_cnt", rd_cnt, 1);
        check("t6_driving", sda_oe_o, 1);
        check("t6_state_rdata", dbg_state_o, 7);
        aresetn = 1'b0;
        #1;
        check("t6_async_release", sda_oe_o, 0);
        check("t6_regs_cleared", |regs_o, 0);
        check("t6_busy", busy_o, 0);
        for (int k = 0; k < 16; k++) exp_regs[k] = 8'h00;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        quarter();
        i2c_stop();
        obs_q.delete();
        i2c_start();
        send_byte(8'hA0, -1, ack); check("t6_post_addr_ack", ack, 1);
        send_byte(8'h07, -1, ack); check("t6_post_ptr_ack", ack, 1);
        send_byte(8'h3C, -1, ack); check("t6_post_d_ack", ack, 1); exp_write(4'd7, 8'h3C);
        i2c_stop();
        check_wr("t6");
        check("t6_reg7", reg_of(7), 8'h3C);

        // 2-cycle SCL low glitch inside the pointer byte is ignored
        i2c_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h05, 3, ack); check("t7_ptr_ack", ack, 1);
        send_byte(8'h5A, 6, ack); check("t7_d_ack", ack, 1); exp_write(4'd5, 8'h5A);
        i2c_stop();
        check_wr("t7");
        check_bank("final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
